// File: rtl/dm_ctrl_if.sv
// Request/response bundle between the MEM stage and the data-memory controller.
interface dm_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dm_ctrl.sv
// Data-memory controller: byte/half/word access, registered response, hardware clear.
// Optional store trace printing enabled by defining DM_CTRL_TRACE_EN.
//   state   | meaning
//   S_CLEAR | zeroing word[clr_idx] each cycle, requests blocked
//   S_IDLE  | accepting one request per cycle
module dm_ctrl #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        clr_start,
   output logic        busy,
   dm_ctrl_if.slave    bus
);

   localparam int unsigned            DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0]  LAST_IDX = DEPTH_LOG2'(DEPTH - 1);

   typedef enum logic {S_CLEAR, S_IDLE} state_t;

   state_t                 state_q, state_d;
   logic [DEPTH_LOG2-1:0]  clr_idx_q, clr_idx_d;
   logic [31:0]            mem [DEPTH];

   logic [31:0]            off;
   logic                   in_range;
   logic [DEPTH_LOG2-1:0]  widx;
   logic [1:0]             lane;
   logic                   accept;
   logic                   size_err;
   logic                   err;
   logic                   wr_en;
   logic [3:0]             be;
   logic [31:0]            wr_lanes;
   logic [31:0]            rd_word;
   logic [31:0]            rd_shift;
   logic [31:0]            ld_data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_CLEAR;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      clr_idx_d     = clr_idx_q;
      busy          = 1'b0;
      bus.req_ready = 1'b0;
      case (state_q)
         S_CLEAR: begin
            busy      = 1'b1;
            clr_idx_d = clr_idx_q + DEPTH_LOG2'(1);
            if (clr_idx_q == LAST_IDX) state_d = S_IDLE;
         end
         S_IDLE: begin
            // clr_start wins over a same-cycle request by withdrawing ready
            if (clr_start) begin
               state_d   = S_CLEAR;
               clr_idx_d = '0;
            end else begin
               bus.req_ready = 1'b1;
            end
         end
         default: state_d = S_CLEAR;
      endcase
   end

   assign off      = bus.req_addr - BASE_ADDR;
   assign in_range = (off[31:DEPTH_LOG2+2] == '0);
   assign widx     = off[DEPTH_LOG2+1:2];
   assign lane     = off[1:0];
   assign accept   = bus.req_valid && bus.req_ready;

   always_comb begin
      size_err = 1'b0;
      be       = 4'b0000;
      wr_lanes = bus.req_wdata;
      case (bus.req_size)
         2'b00: begin
            be       = 4'b0001 << lane;
            wr_lanes = {4{bus.req_wdata[7:0]}};
         end
         2'b01: begin
            size_err = lane[0];
            be       = lane[1] ? 4'b1100 : 4'b0011;
            wr_lanes = {2{bus.req_wdata[15:0]}};
         end
         2'b10: begin
            size_err = (lane != 2'b00);
            be       = 4'b1111;
         end
         default: size_err = 1'b1;
      endcase
   end

   assign err   = size_err || !in_range;
   assign wr_en = accept && bus.req_we && !err;

   // Array has no reset; the clear sequencer owns initialisation.
   always_ff @(posedge clk) begin
      if (busy) begin
         mem[clr_idx_q] <= '0;
      end else if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[widx][8*b +: 8] <= wr_lanes[8*b +: 8];
         end
      end
   end

   assign rd_word  = mem[widx];
   assign rd_shift = rd_word >> {lane, 3'b000};

   always_comb begin
      ld_data = rd_word;
      case (bus.req_size)
         2'b00:   ld_data = {{24{!bus.req_unsigned && rd_shift[7]}},  rd_shift[7:0]};
         2'b01:   ld_data = {{16{!bus.req_unsigned && rd_shift[15]}}, rd_shift[15:0]};
         default: ld_data = rd_word;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= 1'b0;
         bus.rsp_rdata <= '0;
      end else if (accept) begin
         bus.rsp_valid <= 1'b1;
         bus.rsp_err   <= err;
         bus.rsp_rdata <= (err || bus.req_we) ? 32'h0 : ld_data;
      end else begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= 1'b0;
         bus.rsp_rdata <= '0;
      end
   end

`ifdef DM_CTRL_TRACE_EN
   logic [31:0] new_word;

   always_comb begin
      new_word = rd_word;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) new_word[8*b +: 8] = wr_lanes[8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) $display("@%h: *%h <= %h", pc - 32'd4, {bus.req_addr[31:2], 2'b00}, new_word);
   end
`else
   logic unused_pc;
   assign unused_pc = ^pc;
`endif

endmodule

// File: doc/dm_ctrl.md
Name: dm_ctrl

Overview:
- Parametrised data-memory controller; successor to the single-cycle word-only data memory.
- Adds byte/half/word access with sign/zero extension, a valid/ready request handshake, a registered 1-cycle read response, and alignment/range error reporting.
- Adds a hardware clear sequencer that zeroes the array one word per cycle after reset, or on request.
- Sits between the MEM-stage address/store-data path and the writeback mux.

Parameters:
- DEPTH_LOG2, 10, log2 of number of 32-bit words (default 1024 words, 4 KiB).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to 4*2^DEPTH_LOG2.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc  in  32  PC of the instruction issuing the request; used only by the trace feature.
- clr_start  in  1  one-cycle pulse, honoured only in IDLE; re-runs the clear sequence.
- busy  out  1  high while clearing.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, out of range, or illegal size; qualified by rsp_valid.

Behaviour:
- Reset (reset=0, async) forces state CLEAR with clear index 0.
  - Outputs during reset: req_ready=0, busy=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - A pending response is discarded; a clear in progress restarts from 0.
- State CLEAR:
  - Writes 0 to word[idx] each cycle, then idx++; req_ready=0, busy=1.
  - After writing word DEPTH-1, next state is IDLE. Clear takes exactly 2^DEPTH_LOG2 cycles.
- State IDLE: req_ready=1, busy=0.
  - clr_start=1 goes to CLEAR at idx 0; clr_start has priority over a same-cycle req_valid, which is not accepted (req_ready already 1 combinationally, so the requester must hold; clr_start drops req_ready combinationally).
  - clr_start in CLEAR is ignored.
- Accept occurs when req_valid && req_ready at a rising edge. One request per cycle, fully pipelined, no back-pressure in IDLE.
- Address decode:
  - off = req_addr - BASE_ADDR.
  - In range iff off < 4*2^DEPTH_LOG2.
  - Word index = off[DEPTH_LOG2+1:2]; lane = off[1:0].
- Error if any of the following, and then no array write occurs:
  - size=11;
  - half with lane[0]=1;
  - word with lane!=0;
  - out of range.
- Store, committed at the accept edge:
  - byte: lane-selected byte = wdata[7:0].
  - half: lane 0 -> bytes 1:0, lane 2 -> bytes 3:2, taking wdata[15:0].
  - word: all 4 bytes.
  - Other bytes are unchanged.
- Response: rsp_valid=1 exactly in the cycle after accept.
  - Store: rsp_rdata=0.
  - Load: rsp_rdata = selected byte/half/word, sign/zero-extended per req_unsigned.
  - Word loads ignore req_unsigned.
  - Error: rsp_err=1, rsp_rdata=0.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data.
- Response registers hold 0 when rsp_valid=0.

Optional Feature:
- Macro DM_CTRL_TRACE_EN.
- Defined: each committed store prints "@%h: *%h <= %h" with pc-4, the word-aligned address, and the full resulting 32-bit word. Errored stores print nothing. Clear-sequencer writes print nothing.
- Not defined: no $display, no simulation-only logic; pc is unused.

Test Plan:
- Release reset with DEPTH_LOG2=4 -> busy=1 and req_ready=0 for exactly 16 cycles, then busy=0, req_ready=1; every word reads 0.
- Store word 0x8000_00F0 to addr 0x8, then load byte unsigned at 0xB and byte signed at 0x8 -> rsp_rdata 0x0000_0080, then 0xFFFF_FFF0; each arrives one cycle after accept.
- Store half 0xBEEF to 0x12, then load word 0x10 -> 0xBEEF_0000; load half signed 0x12 -> 0xFFFF_BEEF.
- Store word at 0x6, load half at 0x1, size=11, and address 4*DEPTH -> each gives rsp_err=1, rsp_rdata=0, and memory is unchanged.
- Back-to-back store 0x1234_5678 to 0x20 followed immediately by a load of 0x20 -> the load returns 0x1234_5678; then assert reset mid-sequence -> rsp_valid=0 immediately and the clear restarts.
- clr_start and req_valid in the same cycle -> request not accepted, busy rises next cycle, and memory is zeroed after 2^DEPTH_LOG2 cycles.
